// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the shared data bus, one registered one-hot grant at a time
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   req      per-requester level request
//   done     per-requester release strobe, only the owner's bit matters
//   grant    one-hot registered grant, drives the owner's bus enable
//   grant_id owner index, 0 while nobody owns the bus
//   bus_busy OR of grant
//   timeout  one-cycle pulse in the turnaround after a forced release
// Define BUS_ARB_TIMEOUT_EN to compile in the HOLD_MAX hold counter and forced release;
// without it a grant lasts until the owner signals done or drops req, and timeout is 0.
module bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           done,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       bus_busy,
    output logic                       timeout
);
    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || HOLD_MAX < 2) begin : g_bad_cfg
        $error("bus_arbiter: unsupported N_REQ or HOLD_MAX");
    end

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    grant_id_q, grant_id_d;
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0] rot;
    logic [IW-1:0]    win;
    logic [IW-1:0]    ptr_nxt;
    logic             in_grant;
    logic             pick;
    logic             own_done;
    logic             own_req;
    logic             rel;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic          hold_hit;
`endif

    // Rotate requests so that bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        dbl = {req, req} >> ptr_q;
        rot = dbl[N_REQ-1:0];
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (rot[i]) win = IW'((int'(ptr_q) + i) % N_REQ);
    end

    // Owner's done/req are picked out with the one-hot grant, so other bits never matter.
    assign in_grant = state_q == GRANT;
    assign pick     = (state_q == IDLE || state_q == RELEASE) && |req;
    assign own_done = |(grant_q & done);
    assign own_req  = |(grant_q & req);
    assign ptr_nxt  = (grant_id_q == IW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
    assign hold_hit = cnt_q == CW'(HOLD_MAX - 1);
    assign rel      = own_done || !own_req || hold_hit;
`else
    assign rel      = own_done || !own_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d = in_grant ? (rel ? RELEASE : GRANT) : (pick ? GRANT : IDLE);
    end

    always_comb begin
        grant_d    = in_grant ? (rel ? '0 : grant_q) : (pick ? {{(N_REQ-1){1'b0}}, 1'b1} << win : '0);
        grant_id_d = in_grant ? (rel ? '0 : grant_id_q) : (pick ? win : '0);
        ptr_d      = (in_grant && rel) ? ptr_nxt : ptr_q;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d      = !in_grant ? '0 : (cnt_q == CW'(HOLD_MAX)) ? cnt_q : cnt_q + 1'b1;
        // A same-edge done or dropped request is a normal release, not a timeout.
        timeout_d  = in_grant && hold_hit && !own_done && own_req;
`endif
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign bus_busy = |grant_q;
`ifdef BUS_ARB_TIMEOUT_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of round-robin grant, turnaround, timeout and reset behaviour
module tb_bus_arbiter;
    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       bus_busy;
    logic       timeout;
    int         checks;
    int         errors;

    bus_arbiter #(.N_REQ(4), .HOLD_MAX(8)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .grant(grant), .grant_id(grant_id), .bus_busy(bus_busy), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        req    = 4'b1111;
        done   = 4'b0000;
        step();
        step();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_id", 32'(grant_id), 0);
        chk("rst_busy", 32'(bus_busy), 0);
        chk("rst_timeout", 32'(timeout), 0);
        reset = 1'b0;
        step();
        chk("first_grant", 32'(grant), 1);
        chk("first_busy", 32'(bus_busy), 1);

        for (int o = 0; o < 4; o++) begin
            chk("rr_grant", 32'(grant), 1 << o);
            chk("rr_id", 32'(grant_id), o);
            step();
            chk("rr_hold", 32'(grant), 1 << o);
            done = 4'(1 << o);
            step();
            chk("rr_gap_grant", 32'(grant), 0);
            chk("rr_gap_busy", 32'(bus_busy), 0);
            chk("rr_gap_id", 32'(grant_id), 0);
            done = 4'b0000;
            step();
        end
        chk("rr_wrap", 32'(grant), 1);

        done = 4'b0001;
        step();
        done = 4'b0000;
        step();
        chk("owner1", 32'(grant), 2);
        done = 4'b1000;
        step();
        chk("nonowner_done", 32'(grant), 2);
        step();
        chk("nonowner_done2", 32'(grant), 2);
        done = 4'b0000;
        req  = 4'b1101;
        step();
        chk("req_drop_gap", 32'(grant), 0);
        step();
        chk("req_drop_next", 32'(grant), 4);
        chk("req_drop_id", 32'(grant_id), 2);

        req = 4'b1100;
`ifdef BUS_ARB_TIMEOUT_EN
        for (int c = 2; c <= 8; c++) begin
            step();
            chk("to_hold", 32'(grant), 4);
            chk("to_hold_pulse", 32'(timeout), 0);
        end
        step();
        chk("to_release", 32'(grant), 0);
        chk("to_pulse", 32'(timeout), 1);
        step();
        chk("to_next", 32'(grant), 8);
        chk("to_pulse_end", 32'(timeout), 0);
`else
        for (int c = 0; c < 12; c++) begin
            step();
            chk("noto_hold", 32'(grant), 4);
            chk("noto_pulse", 32'(timeout), 0);
        end
        done = 4'b0100;
        step();
        chk("noto_release", 32'(grant), 0);
        done = 4'b0000;
        step();
        chk("noto_next", 32'(grant), 8);
`endif

        for (int c = 2; c <= 8; c++) step();
        chk("sim_hold", 32'(grant), 8);
        done = 4'b1000;
        step();
        chk("sim_release", 32'(grant), 0);
        chk("sim_no_timeout", 32'(timeout), 0);
        done = 4'b0000;
        step();
        chk("sim_next", 32'(grant), 4);
        chk("sim_next_id", 32'(grant_id), 2);

        #3;
        reset = 1'b1;
        #1;
        chk("async_grant", 32'(grant), 0);
        chk("async_busy", 32'(bus_busy), 0);
        chk("async_id", 32'(grant_id), 0);
        req = 4'b0101;
        step();
        chk("rst_hold", 32'(grant), 0);
        reset = 1'b0;
        step();
        chk("ptr_reset", 32'(grant), 1);
        done = 4'b0001;
        step();
        chk("ptr_reset_gap", 32'(grant), 0);
        done = 4'b0000;
        step();
        chk("ptr_reset_next", 32'(grant), 4);

        reset = 1'b1;
        req   = 4'b1010;
        step();
        reset = 1'b0;
        step();
        chk("skip_first", 32'(grant), 2);
        chk("skip_first_id", 32'(grant_id), 1);
        done = 4'b0010;
        step();
        chk("skip_gap", 32'(grant), 0);
        done = 4'b0000;
        step();
        chk("skip_second", 32'(grant), 8);
        chk("skip_second_id", 32'(grant_id), 3);
        done = 4'b1000;
        step();
        done = 4'b0000;
        step();
        chk("skip_wrap", 32'(grant), 2);

        req = 4'b0000;
        step();
        chk("idle_gap", 32'(grant), 0);
        step();
        chk("idle_stay", 32'(grant), 0);
        chk("idle_busy", 32'(bus_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
